// File: rtl/booth_r8_encoder_pipe.sv
// Two-stage radix-8 Booth recoder for a WIDTH-bit multiplier operand.
// Stage 1 registers the operand and stage 2 registers the per-group selects.
module booth_r8_encoder_pipe #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   mx,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH/3:0]   s,
    output logic [WIDTH/3:0]   d,
    output logic [WIDTH/3:0]   t,
    output logic [WIDTH/3:0]   q,
    output logic [WIDTH/3:0]   n
);

    localparam int G  = WIDTH / 3 + 1;
    localparam int XW = 3 * G + 1;

    logic             en;
    logic             v1_q;
    logic             v2_q;
    logic [WIDTH-1:0] mx_q;
    logic             sgn_q;
    logic [G-1:0]     s_q, d_q, t_q, q_q, n_q;
    logic [G-1:0]     s_d, d_d, t_d, q_d, n_d;
    logic [XW-1:0]    xExt;
    logic [3:0]       win;
    logic             a0, a1, a2;

    assign en       = ~v2_q | out_ready;
    assign in_ready = en;

    // Bit 0 of xExt is the implicit x[-1]=0, so group k's window is xExt[3k+3:3k].
    always_comb begin
        xExt            = '0;
        xExt[WIDTH:1]   = mx_q;
        for (int i = WIDTH + 1; i < XW; i++) begin
            xExt[i] = sgn_q & mx_q[WIDTH-1];
        end
    end

    always_comb begin
        s_d = '0;
        d_d = '0;
        t_d = '0;
        q_d = '0;
        n_d = '0;
        win = '0;
        a0  = 1'b0;
        a1  = 1'b0;
        a2  = 1'b0;
        for (int k = 0; k < G; k++) begin
            win    = xExt[3*k +: 4];
            a0     = win[0] ^ win[1];
            a1     = win[1] ^ win[2];
            a2     = win[2] ^ win[3];
            n_d[k] = win[3];
            s_d[k] = a0 & ~a2;
            d_d[k] = a1 & ~a0;
            t_d[k] = a2 & a0;
            q_d[k] = a2 & ~a0 & ~a1;
        end
    end

    // Both stages advance together; data registers only load behind a valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            mx_q  <= '0;
            sgn_q <= 1'b0;
            v2_q  <= 1'b0;
            s_q   <= '0;
            d_q   <= '0;
            t_q   <= '0;
            q_q   <= '0;
            n_q   <= '0;
        end else if (en) begin
            v1_q <= in_valid;
            if (in_valid) begin
                mx_q  <= mx;
                sgn_q <= in_signed;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                s_q <= s_d;
                d_q <= d_d;
                t_q <= t_d;
                q_q <= q_d;
                n_q <= n_d;
            end
        end
    end

    assign out_valid = v2_q;
    assign s         = s_q;
    assign d         = d_q;
    assign t         = t_q;
    assign q         = q_q;
    assign n         = n_q;

endmodule

// File: doc/booth_r8_encoder_pipe.md
BOOTH_R8_ENCODER_PIPE -- requirements
Module: booth_r8_encoder_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the multiplier operand width; legal range 4..64.
REQ-002 The block SHALL derive localparam G = WIDTH/3 + 1 (integer division), giving the Booth group count; G = 6 at WIDTH=16.
REQ-003 The block SHALL use one clock, clk; reset rst_n is synchronous and active-low.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst_n  input  1  synchronous active-low reset.
REQ-006 Port in_valid  input  1  operand on mx/in_signed is valid this cycle.
REQ-007 Port in_ready  output  1  block accepts the operand this cycle.
REQ-008 Port mx  input  WIDTH  multiplier operand.
REQ-009 Port in_signed  input  1  1 = two's-complement mx, 0 = unsigned mx.
REQ-010 Port out_valid  output  1  encoded group set valid.
REQ-011 Port out_ready  input  1  downstream accepts the group set.
REQ-012 Ports s, d, t, q, n  output  G each  per-group single/double/triple/quad/negate selects; bit k belongs to group k.

Function
REQ-013 The extended operand SHALL be: x[-1]=0; x[i]=mx[i] for 0<=i<WIDTH; for i>=WIDTH, x[i]=mx[WIDTH-1] when in_signed=1 and 0 otherwise.
REQ-014 The group-k window SHALL be w = {x[3k+2], x[3k+1], x[3k], x[3k-1]} for k = 0..G-1.
REQ-015 With a0=w0^w1, a1=w1^w2, a2=w2^w3, the block SHALL produce: n=w3; s=a0&~a2; d=a1&~a0; t=a2&a0; q=a2&~a0&~a1.
REQ-016 For every window, at most one of s/d/t/q SHALL be 1; windows 0000 and 1111 give all selects 0, with n equal to w3.
REQ-017 Digit value -4*w3+2*w2+w1+w0 SHALL equal (s+2d+3t+4q)*(n?-1:1) in each group; the sum over k of digit_k*8^k SHALL equal mx, interpreted per in_signed.
REQ-018 The pipeline SHALL have two register stages: stage 1 captures mx, in_signed and valid; stage 2 captures the encoded s/d/t/q/n and valid.
REQ-019 Latency SHALL be exactly 2 cycles from the accept edge to out_valid=1 when out_ready stays high.
REQ-020 Throughput SHALL be one operand per cycle with no bubbles while out_ready=1.
REQ-021 Global advance enable SHALL be en = ~out_valid | out_ready; both stages load only when en=1.
REQ-022 in_ready SHALL equal en, as a combinational path from out_ready and the stage-2 valid register.
REQ-023 An operand SHALL be accepted iff in_valid & in_ready at a rising edge; when in_valid=0 with en=1, a bubble (valid=0) SHALL advance.
REQ-024 While out_valid=1 and out_ready=0, s/d/t/q/n and out_valid SHALL hold stable, and stage 1 SHALL hold its contents.
REQ-025 A bubble in stage 2 (out_valid=0) SHALL be overwritten regardless of out_ready.
REQ-026 When out_valid=0, s/d/t/q/n SHALL be don't-care for the consumer; the implementation still holds their last registered value.

Reset
REQ-027 When rst_n=0 at a rising edge, both valid registers, all stage-1 data and s/d/t/q/n SHALL become 0.
REQ-028 Reset SHALL dominate in_valid and out_ready; in-flight operands SHALL be discarded with no partial output.
REQ-029 in_ready SHALL read 1 in the first cycle after reset is released.

Verification
REQ-030 WIDTH=16, unsigned, mx=0x0007, out_ready=1 -> 2 cycles later: s=000011, n=000001, d=t=q=000000.
REQ-031 WIDTH=16, mx=0xFFFF -> unsigned: s=000001, d=100000, n=011111, t=q=0; signed: s=000001, n=111111, d=t=q=0.
REQ-032 WIDTH=16, unsigned, mx=0x0003 -> t=000001, all others 0; mx=0x0004 -> q=000001, s=000010, n=000001, d=t=0.
REQ-033 Backpressure: stream mx=1,2,3,4 and hold out_ready=0 for 3 cycles after the first out_valid -> outputs stay frozen, in_ready=0, and all four results appear in order with none lost or duplicated.
REQ-034 Reset mid-stream: assert rst_n=0 for 1 cycle with 2 operands in flight -> out_valid=0 and all outputs 0 the next cycle; those operands never emerge.
REQ-035 Random self-check, WIDTH in {8,15,16,32}, both modes, random in_valid/out_ready -> sum over k of digit_k*8^k equals mx for every transfer, and REQ-016 holds for every group.
